// File: rtl/usb_device_attach_pkg.sv
// Shared speed and linestate encodings for the USB device attach controller.
package usb_device_attach_pkg;

  typedef logic [1:0] usb_speed_t;

  localparam usb_speed_t USB_SPEED_AUTO = 2'b00;
  localparam usb_speed_t USB_SPEED_LS   = 2'b01;
  localparam usb_speed_t USB_SPEED_FS   = 2'b10;
  localparam usb_speed_t USB_SPEED_HS   = 2'b11;

  // Linestate as {fe_linestate1, fe_linestate0}
  localparam logic [1:0] LINESTATE_SE0 = 2'b00;
  localparam logic [1:0] LINESTATE_J   = 2'b01;
  localparam logic [1:0] LINESTATE_K   = 2'b10;

  // Anything the build cannot honour (AUTO, or HS without the chirp path) settles at FS.
  function automatic usb_speed_t resolve_target(input usb_speed_t req, input logic hs_en);
    if (req == USB_SPEED_LS) return USB_SPEED_LS;
    if (req == USB_SPEED_HS && hs_en) return USB_SPEED_HS;
    return USB_SPEED_FS;
  endfunction

endpackage

// File: rtl/usb_chirp_counter.sv
// Host chirp detector: counts alternating K/J tokens of at least kj_min+1 cycles.
// Held cleared whenever enable is low; hs_ok flags the cycle the sixth token completes.
module usb_chirp_counter
  import usb_device_attach_pkg::*;
#(
  parameter int pCOUNTER_WIDTH = 24
) (
  input  logic                      fe_clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic [1:0]                linestate,
  input  logic [pCOUNTER_WIDTH-1:0] kj_min,
  output logic                      hs_ok
);

  logic [pCOUNTER_WIDTH-1:0] tok_timer;
  logic [2:0]                tok_count;
  logic                      expect_j;
  logic [1:0]                expected;
  logic                      tok_hit;

  assign expected = expect_j ? LINESTATE_J : LINESTATE_K;
  assign tok_hit  = enable && (linestate == expected) && (tok_timer == kj_min);
  assign hs_ok    = tok_hit && (tok_count == 3'd5);

  // SE0 or the wrong symbol only restarts the current token; completed tokens are kept.
  always_ff @(posedge fe_clk) begin
    if (!reset_n || !enable) begin
      tok_timer <= '0;
      tok_count <= 3'd0;
      expect_j  <= 1'b0;
    end else if (tok_hit) begin
      tok_timer <= '0;
      tok_count <= tok_count + 3'd1;
      expect_j  <= ~expect_j;
    end else if (linestate == expected) begin
      tok_timer <= tok_timer + pCOUNTER_WIDTH'(1);
    end else begin
      tok_timer <= '0;
    end
  end

endmodule

// File: rtl/usb_device_attach.sv
// Device-side USB attach and high-speed detection handshake controller.
// Define USB_ATTACH_HS_EN to build the chirp path; without it HS targets settle at FS.
module usb_device_attach
  import usb_device_attach_pkg::*;
#(
  parameter int pCOUNTER_WIDTH = 24
) (
  input  logic                      fe_clk,
  input  logic                      reset_n,
  input  logic                      fe_linestate0,
  input  logic                      fe_linestate1,
  input  logic                      I_start,
  input  logic                      I_disconnect,
  input  logic [1:0]                I_target_speed,
  input  logic [pCOUNTER_WIDTH-1:0] I_reset_time,
  input  logic [pCOUNTER_WIDTH-1:0] I_chirp_time,
  input  logic [pCOUNTER_WIDTH-1:0] I_chirp_timeout,
  input  logic [pCOUNTER_WIDTH-1:0] I_kj_min,
  output logic                      O_pullup_en,
  output logic                      O_pullup_sel,
  output logic                      O_tx_chirp_k,
  output logic                      O_hs_term,
  output logic [1:0]                O_speed,
  output logic                      O_busy,
  output logic                      O_done
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ATTACH     = 3'd1;
  localparam logic [2:0] ST_CHIRP_K    = 3'd2;
  localparam logic [2:0] ST_WAIT_CHIRP = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

`ifdef USB_ATTACH_HS_EN
  localparam logic HS_EN = 1'b1;
`else
  localparam logic HS_EN = 1'b0;
`endif

  logic [2:0]                state, state_nxt;
  logic [pCOUNTER_WIDTH-1:0] timer, timer_nxt;
  logic [pCOUNTER_WIDTH-1:0] reset_time_q;
  usb_speed_t                tgt_q, tgt_nxt, speed_nxt;
  logic [1:0]                linestate;
  logic                      start_ok;
  logic                      pullup_en_nxt, pullup_sel_nxt, chirp_k_nxt, hs_term_nxt;
  logic                      busy_nxt, done_nxt;

  assign linestate = {fe_linestate1, fe_linestate0};
  assign start_ok  = (state == ST_IDLE) && I_start && !I_disconnect;
  assign tgt_nxt   = start_ok ? resolve_target(I_target_speed, HS_EN) : tgt_q;

  always_ff @(posedge fe_clk) begin
    if (start_ok) begin
      reset_time_q <= I_reset_time;
      tgt_q        <= resolve_target(I_target_speed, HS_EN);
    end
  end

`ifdef USB_ATTACH_HS_EN
  logic [pCOUNTER_WIDTH-1:0] chirp_time_q, chirp_timeout_q, kj_min_q;
  logic                      hs_ok;

  always_ff @(posedge fe_clk) begin
    if (start_ok) begin
      chirp_time_q    <= I_chirp_time;
      chirp_timeout_q <= I_chirp_timeout;
      kj_min_q        <= I_kj_min;
    end
  end

  usb_chirp_counter #(
    .pCOUNTER_WIDTH(pCOUNTER_WIDTH)
  ) u_chirp_counter (
    .fe_clk    (fe_clk),
    .reset_n   (reset_n),
    .enable    (state == ST_WAIT_CHIRP),
    .linestate (linestate),
    .kj_min    (kj_min_q),
    .hs_ok     (hs_ok)
  );
`else
  logic unused_hs_inputs;
  assign unused_hs_inputs = ^{I_chirp_time, I_chirp_timeout, I_kj_min};
`endif

  // Timers start at zero on state entry and advance only while the state holds.
  always_comb begin
    state_nxt = state;
    speed_nxt = O_speed;
    timer_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (I_start) state_nxt = ST_ATTACH;
      end
      ST_ATTACH: begin
        if (linestate == LINESTATE_SE0) begin
          if (timer == reset_time_q) begin
            state_nxt = ST_DONE;
            speed_nxt = tgt_q;
`ifdef USB_ATTACH_HS_EN
            if (tgt_q == USB_SPEED_HS) state_nxt = ST_CHIRP_K;
`endif
          end else begin
            timer_nxt = timer + pCOUNTER_WIDTH'(1);
          end
        end
      end
`ifdef USB_ATTACH_HS_EN
      ST_CHIRP_K: begin
        if (timer == chirp_time_q) state_nxt = ST_WAIT_CHIRP;
        else timer_nxt = timer + pCOUNTER_WIDTH'(1);
      end
      ST_WAIT_CHIRP: begin
        // A sixth token landing on the timeout cycle still counts as HS.
        if (hs_ok) begin
          state_nxt = ST_DONE;
          speed_nxt = USB_SPEED_HS;
        end else if (timer == chirp_timeout_q) begin
          state_nxt = ST_DONE;
          speed_nxt = USB_SPEED_FS;
        end else begin
          timer_nxt = timer + pCOUNTER_WIDTH'(1);
        end
      end
`endif
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_IDLE;
    endcase
    if (I_disconnect) state_nxt = ST_IDLE;
    if (state_nxt != ST_DONE) speed_nxt = USB_SPEED_AUTO;
  end

  always_comb begin
    busy_nxt       = state_nxt inside {ST_ATTACH, ST_CHIRP_K, ST_WAIT_CHIRP};
    done_nxt       = (state_nxt == ST_DONE);
    pullup_en_nxt  = busy_nxt || (done_nxt && speed_nxt != USB_SPEED_HS);
    pullup_sel_nxt = (state_nxt != ST_IDLE) && (tgt_nxt == USB_SPEED_LS);
`ifdef USB_ATTACH_HS_EN
    chirp_k_nxt    = (state_nxt == ST_CHIRP_K);
    hs_term_nxt    = done_nxt && (speed_nxt == USB_SPEED_HS);
`else
    chirp_k_nxt    = 1'b0;
    hs_term_nxt    = 1'b0;
`endif
  end

  // Outputs are registered from the next state so they change on the entry edge.
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      timer        <= '0;
      O_pullup_en  <= 1'b0;
      O_pullup_sel <= 1'b0;
      O_tx_chirp_k <= 1'b0;
      O_hs_term    <= 1'b0;
      O_busy       <= 1'b0;
      O_done       <= 1'b0;
      O_speed      <= USB_SPEED_AUTO;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      O_pullup_en  <= pullup_en_nxt;
      O_pullup_sel <= pullup_sel_nxt;
      O_tx_chirp_k <= chirp_k_nxt;
      O_hs_term    <= hs_term_nxt;
      O_busy       <= busy_nxt;
      O_done       <= done_nxt;
      O_speed      <= speed_nxt;
    end
  end

endmodule
